midi_msg_parser: RTL
====================

# midi_msg_parser

Byte-level MIDI message parser sitting directly downstream of the serial receiver. Consumes one received byte per `rx_valid` strobe, tracks channel status (including running status), and emits one-cycle note-on/note-off events with channel, note and velocity. Also maintains a held-note register that drives the note LEDs and a saturating count of orphan data bytes.

## Interface
Parameters:
- `CHANNEL`, 4'd0: channel accepted when `OMNI`=0.
- `OMNI`, 1: 1 = accept all 16 channels; 0 = accept only `CHANNEL`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per byte; may be asserted on consecutive cycles.
- `ev_valid`  out  1  one-cycle event strobe.
- `ev_on`  out  1  1 = note-on, 0 = note-off.
- `ev_chan`  out  4  channel of event.
- `ev_note`  out  7  note number.
- `ev_vel`  out  7  velocity; forced to 0 for every note-off event.
- `held_note`  out  8  bit7 = note active, [6:0] = last note turned on.
- `err_cnt`  out  8  saturating count of data bytes received with no status.

## Operation
- Byte classes: status = bit7=1; data = bit7=0; realtime = 0xF8–0xFF.
- Realtime bytes are ignored completely: no state, register or output change, even mid-message.
- States: IDLE (no status), WAIT_D1 (note status held, awaiting note byte), WAIT_D2 (awaiting velocity), SKIP (consume data bytes silently).
- Status byte, from any state:
  - 0x8n/0x9n with accepted channel: latch status, go WAIT_D1.
  - 0x8n/0x9n with rejected channel, any other 0x80–0xEF, or 0xF0 (sysex start): go SKIP.
  - 0xF1–0xF7: go IDLE, clear latched status.
- A status byte arriving in WAIT_D2 aborts the partial message; no event.
- Data byte:
  - IDLE: increment `err_cnt` (saturate at 0xFF), stay IDLE.
  - SKIP: ignore, stay SKIP.
  - WAIT_D1: latch note, go WAIT_D2.
  - WAIT_D2: emit event, return per running-status rule (Configuration).
- Event decode: 0x9n with velocity>0 -> `ev_on`=1, `ev_vel`=velocity. 0x9n with velocity 0, or 0x8n with any velocity -> `ev_on`=0, `ev_vel`=0.
- `held_note` updates on the same edge as the event:
  - Note-on: `held_note` = {1, note}.
  - Note-off whose note equals `held_note[6:0]` while bit7=1: clear bit7, keep [6:0].
  - Note-off for any other note: no change.

## Timing
- Reset: state IDLE, latched status cleared, `ev_valid`=0, `ev_on`=0, `ev_chan`=0, `ev_note`=0, `ev_vel`=0, `held_note`=0, `err_cnt`=0.
- Latency: `ev_valid` is high exactly one cycle, on the cycle after the clock edge that samples the completing `rx_valid`. `ev_*` fields are registered and hold their values until the next event.
- Throughput: one byte per cycle. Back-to-back `rx_valid` must be handled with no lost byte, including an event cycle that coincides with the next byte.
- `rst_n` low mid-message: all state returns to reset values on that edge. A pending partial message is discarded; no event is emitted.
- `err_cnt` holds at 0xFF; it is never cleared except by reset.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - After an event, the parser returns to WAIT_D1 with status retained.
  - Further data-byte pairs produce events without a new status byte.
- Not defined:
  - After an event, the parser goes to IDLE and clears the latched status.
  - Following data bytes count toward `err_cnt`.

## Test plan
- Reset, then send 0x90,0x3C,0x64 -> one `ev_valid` pulse: `ev_on`=1, `ev_chan`=0, `ev_note`=0x3C, `ev_vel`=0x64; `held_note`=0xBC.
- Then send 0x80,0x3C,0x40 -> `ev_on`=0, `ev_vel`=0, `held_note`=0x3C. Repeat the test with 0x90,0x3C,0x00 for the same result.
- Running status with macro defined: 0x91,0x40,0x10,0x41,0x20 -> two events on channel 1, notes 0x40 then 0x41. Same stimulus without the macro -> one event, then `err_cnt`=2.
- Realtime interleave: 0x90,0xF8,0x3C,0xFE,0x7F, all on consecutive cycles -> a single event, note 0x3C, velocity 0x7F.
- Filtering and abort:
  - With `OMNI`=0, `CHANNEL`=2: 0x93,0x30,0x30 -> no event, `err_cnt` unchanged.
  - 0x92,0x30,0xB2,0x07,0x10 -> no event.
  - 0xF0,0x01,0x02,0xF7 -> no event, `err_cnt` unchanged.
- `err_cnt` saturation and mid-message reset:
  - 300 data bytes after reset -> `err_cnt`=0xFF.
  - Assert `rst_n` low after 0x90,0x3C, then send 0x64 -> no event, all outputs 0.

Source files
------------

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module   : midi_msg_parser
// Purpose  : MIDI byte parser producing note-on/off events, a held-note
//            register and a saturating orphan-data-byte count.
// Options  : MIDI_RUNNING_STATUS_EN keeps the note status after an event.
// Revision : 1.0 - initial release
// ============================================================================
module midi_msg_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  output logic       ev_on,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_note,
  output logic [6:0] ev_vel,
  output logic [7:0] held_note,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_D1 = 2'd1;
  localparam logic [1:0] S_WAIT_D2 = 2'd2;
  localparam logic [1:0] S_SKIP    = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;

  // Latched status reduced to what events need: note-on flag and channel.
  logic       r_stat_on;
  logic [3:0] r_stat_chan;
  logic [6:0] r_note;

  logic       r_ev_valid;
  logic       r_ev_on;
  logic [3:0] r_ev_chan;
  logic [6:0] r_ev_note;
  logic [6:0] r_ev_vel;
  logic [7:0] r_held;
  logic [7:0] r_err;

  logic       w_is_rt;
  logic       w_is_status;
  logic       w_is_data;
  logic       w_note_stat;
  logic       w_chan_ok;
  logic       w_sys_end;

  logic       w_latch_status;
  logic       w_clear_status;
  logic       w_latch_note;
  logic       w_emit;
  logic       w_err_inc;

  logic       w_ev_on;
  logic [6:0] w_ev_vel;
  logic [7:0] w_held_next;

  assign w_is_rt     = rx_valid && (rx_data >= 8'hF8);
  assign w_is_status = rx_valid && rx_data[7] && !w_is_rt;
  assign w_is_data   = rx_valid && !rx_data[7];
  assign w_note_stat = (rx_data[7:5] == 3'b100);
  assign w_chan_ok   = OMNI || (rx_data[3:0] == CHANNEL);
  assign w_sys_end   = (rx_data[7:4] == 4'hF) && (rx_data[3:0] != 4'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_latch_status = 1'b0;
    w_clear_status = 1'b0;
    w_latch_note   = 1'b0;
    w_emit         = 1'b0;
    w_err_inc      = 1'b0;
    if (w_is_status) begin
      if (w_note_stat && w_chan_ok) begin
        w_next_state   = S_WAIT_D1;
        w_latch_status = 1'b1;
      end else if (w_sys_end) begin
        w_next_state   = S_IDLE;
        w_clear_status = 1'b1;
      end else begin
        w_next_state   = S_SKIP;
        w_clear_status = 1'b1;
      end
    end else if (w_is_data) begin
      case (r_state)
        S_IDLE: begin
          w_err_inc = 1'b1;
        end
        S_WAIT_D1: begin
          w_latch_note = 1'b1;
          w_next_state = S_WAIT_D2;
        end
        S_WAIT_D2: begin
          w_emit = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
          w_next_state = S_WAIT_D1;
`else
          w_next_state   = S_IDLE;
          w_clear_status = 1'b1;
`endif
        end
        default: begin
          w_next_state = S_SKIP;
        end
      endcase
    end
  end

  // Velocity 0 on a note-on status is a note-off.
  always_comb begin
    w_ev_on     = r_stat_on && (rx_data[6:0] != 7'd0);
    w_ev_vel    = w_ev_on ? rx_data[6:0] : 7'd0;
    w_held_next = r_held;
    if (w_emit) begin
      if (w_ev_on) begin
        w_held_next = {1'b1, r_note};
      end else if (r_held[7] && (r_held[6:0] == r_note)) begin
        w_held_next = {1'b0, r_note};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_on   <= 1'b0;
      r_stat_chan <= 4'd0;
      r_note      <= 7'd0;
      r_ev_valid  <= 1'b0;
      r_ev_on     <= 1'b0;
      r_ev_chan   <= 4'd0;
      r_ev_note   <= 7'd0;
      r_ev_vel    <= 7'd0;
      r_held      <= 8'd0;
      r_err       <= 8'd0;
    end else begin
      r_ev_valid <= w_emit;
      r_held     <= w_held_next;
      if (w_emit) begin
        r_ev_on   <= w_ev_on;
        r_ev_chan <= r_stat_chan;
        r_ev_note <= r_note;
        r_ev_vel  <= w_ev_vel;
      end
      if (w_latch_status) begin
        r_stat_on   <= rx_data[4];
        r_stat_chan <= rx_data[3:0];
      end else if (w_clear_status) begin
        r_stat_on   <= 1'b0;
        r_stat_chan <= 4'd0;
      end
      if (w_latch_note) begin
        r_note <= rx_data[6:0];
      end
      if (w_err_inc && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign ev_valid  = r_ev_valid;
  assign ev_on     = r_ev_on;
  assign ev_chan   = r_ev_chan;
  assign ev_note   = r_ev_note;
  assign ev_vel    = r_ev_vel;
  assign held_note = r_held;
  assign err_cnt   = r_err;

endmodule
`default_nettype wire
